ans_display: RTL and testbench



---
 rtl/ans_display_pkg.sv | 32 +++
 rtl/ans_display_bin2bcd_iter.sv | 33 +++
 rtl/ans_display.sv | 91 +++++++++
 tb/tb_ans_display.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ans_display_pkg.sv
// ans_display_pkg: FSM states, slot ids and segment encodings shared by ans_display
package ans_display_pkg;
  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2,
    ERR     = 2'd3
  } state_t;
  localparam logic [2:0] SLOT_SIGN = 3'd0;
  localparam logic [2:0] SLOT_HUND = 3'd1;
  localparam logic [2:0] SLOT_TENS = 3'd2;
  localparam logic [2:0] SLOT_ONES = 3'd3;
  localparam logic [2:0] SLOT_GAP  = 3'd4;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'b0111111;
      4'd1: return 7'b0000110;
      4'd2: return 7'b1011011;
      4'd3: return 7'b1001111;
      4'd4: return 7'b1100110;
      4'd5: return 7'b1101101;
      4'd6: return 7'b1111101;
      4'd7: return 7'b0000111;
      4'd8: return 7'b1111111;
      4'd9: return 7'b1101111;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/ans_display_bin2bcd_iter.sv
// bin2bcd_iter: iterative double-dabble, 10-bit binary to 3 BCD digits in 10 cycles
module bin2bcd_iter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [9:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);
  logic [9:0]  sh;
  logic [3:0]  cnt;
  logic [11:0] adj;
  function automatic logic [3:0] add3(input logic [3:0] n);
    return n > 4'd4 ? n + 4'd3 : n;
  endfunction
  assign adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};
  // high during the last shift step; bcd is final after the coming edge
  assign done = cnt == 4'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (start) begin
      sh  <= bin;
      bcd <= '0;
      cnt <= 4'd10;
    end else if (cnt != 4'd0) begin
      {bcd, sh} <= {adj[10:0], sh, 1'b0};
      cnt       <= cnt - 4'd1;
    end
  end
endmodule

// File: rtl/ans_display.sv
// ans_display: shows ans as sign/hundreds/tens/ones/gap on one 7-seg display, 'E' on error.
// Define ZERO_BLANK_EN to blank leading-zero hundreds/tens digits.
module ans_display
  import ans_display_pkg::*;
#(
  parameter int DIGIT_TICKS = 10_000_000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] ans,
  input  logic       error,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);
  state_t            state;
  logic [CNT_W-1:0]  timer;
  logic [2:0]        slot;
  logic              sign;
  logic [9:0]        mag;
  logic              conv_done;
  logic [11:0]       bcd;
  logic [6:0]        hund_seg;
  logic [6:0]        tens_seg;
  logic [6:0]        slot_seg;
  logic              timer_end;
  // -512 negates to itself, which read unsigned is the wanted 512
  assign mag = ans[9] ? -ans : ans;
  bin2bcd_iter u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == CAPTURE),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd)
  );
`ifdef ZERO_BLANK_EN
  assign hund_seg = bcd[11:8] == 4'd0 ? SEG_BLANK : bcd_to_seg(bcd[11:8]);
  assign tens_seg = bcd[11:4] == 8'd0 ? SEG_BLANK : bcd_to_seg(bcd[7:4]);
`else
  assign hund_seg = bcd_to_seg(bcd[11:8]);
  assign tens_seg = bcd_to_seg(bcd[7:4]);
`endif
  assign slot_seg = slot == SLOT_SIGN ? (sign ? SEG_MINUS : SEG_BLANK) :
                    slot == SLOT_HUND ? hund_seg :
                    slot == SLOT_TENS ? tens_seg :
                    slot == SLOT_ONES ? bcd_to_seg(bcd[3:0]) : SEG_BLANK;
  assign timer_end = timer == CNT_W'(DIGIT_TICKS - 1);
  assign busy      = state == CONVERT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CAPTURE;
      timer <= '0;
      slot  <= SLOT_SIGN;
      sign  <= 1'b0;
      seg   <= SEG_BLANK;
      dp    <= 1'b0;
    end else if (error) begin
      state <= ERR;
      timer <= '0;
      slot  <= SLOT_SIGN;
      seg   <= SEG_E;
      dp    <= 1'b0;
    end else begin
      case (state)
        CAPTURE: begin
          sign  <= ans[9];
          state <= CONVERT;
        end
        CONVERT: if (conv_done) begin
          state <= SHOW;
          timer <= '0;
          slot  <= SLOT_SIGN;
        end
        SHOW: begin
          seg <= slot_seg;
          dp  <= slot == SLOT_SIGN;
          if (timer_end) begin
            timer <= '0;
            slot  <= slot == SLOT_GAP ? SLOT_SIGN : slot + 3'd1;
            if (slot == SLOT_GAP) state <= CAPTURE;
          end else begin
            timer <= timer + CNT_W'(1);
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end
endmodule

// File: tb/tb_ans_display.sv
// tb_ans_display: scoreboarded frame checks plus directed busy/error/reset checks
module tb_ans_display;
  localparam int DT = 4;
  localparam logic [6:0] BL = 7'b0000000;
  localparam logic [6:0] MI = 7'b1000000;
  localparam logic [6:0] EE = 7'b1111001;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ans = '0;
  logic       error = 1'b0;
  logic [6:0] seg;
  logic       dp;
  logic       busy;
  logic [6:0] dg [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                          7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
  logic [6:0] sbq [$];
  int n_chk = 0;
  int n_fail = 0;
  int frames_done = 0;
  logic pd;
  ans_display #(.DIGIT_TICKS(DT), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ans   (ans),
    .error (error),
    .seg   (seg),
    .dp    (dp),
    .busy  (busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3);
    sbq.push_back(s0);
    sbq.push_back(s1);
    sbq.push_back(s2);
    sbq.push_back(s3);
    sbq.push_back(BL);
  endtask
  task automatic wait_frames(input int tgt);
    for (int k = 0; k < 100 && frames_done < tgt; k++) begin
      @(negedge clk);
      #1;
    end
    chk("frames_done", frames_done, tgt);
  endtask
  task automatic wait_dp(output int cnt);
    cnt = 0;
    while (cnt < 60 && !dp) begin
      @(negedge clk);
      cnt++;
    end
  endtask
  // monitor: a rising dp marks a frame; each of its 5 slots is held DT cycles
  initial begin
    logic [6:0] e;
    bit ab;
    pd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && dp && !pd) begin
        ab = 0;
        for (int s = 0; s < 5 && !ab; s++) begin
          if (sbq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL frame_unexpected: got frame start, expected none at %0t", $time);
            ab = 1;
          end else begin
            e = sbq.pop_front();
            for (int c = 0; c < DT && !ab; c++) begin
              if (s > 0 || c > 0) @(negedge clk);
              if (!rst_n) begin
                ab = 1;
                for (int k = s + 1; k < 5; k++) if (sbq.size() > 0) void'(sbq.pop_front());
              end else begin
                chk($sformatf("slot%0d_seg", s), int'(seg), int'(e));
                chk($sformatf("slot%0d_dp", s), int'(dp), int'(s == 0));
              end
            end
          end
        end
        if (!ab) frames_done++;
      end
      pd = dp;
    end
  end
  initial begin
    int cnt;
    ans = 10'd123;
    #12;
    chk("reset_seg", int'(seg), 0);
    chk("reset_dp", int'(dp), 0);
    chk("reset_busy", int'(busy), 0);
    push_frame(BL, dg[1], dg[2], dg[3]);
    @(negedge clk);
    rst_n = 1'b1;
    wait_frames(1);
    push_frame(BL, dg[1], dg[2], dg[3]);
`ifdef ZERO_BLANK_EN
    push_frame(BL, BL, dg[4], dg[5]);
`else
    push_frame(BL, dg[0], dg[4], dg[5]);
`endif
    chk("capture_busy", int'(busy), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("convert_busy%0d", i), int'(busy), 1);
    end
    @(negedge clk);
    chk("show_busy", int'(busy), 0);
    wait_dp(cnt);
    repeat (9) @(negedge clk);
    ans = 10'd45;
    wait_frames(3);
    ans = 10'h3FF;
`ifdef ZERO_BLANK_EN
    push_frame(MI, BL, BL, dg[1]);
`else
    push_frame(MI, dg[0], dg[0], dg[1]);
`endif
    wait_frames(4);
    ans = 10'h200;
    push_frame(MI, dg[5], dg[1], dg[2]);
    wait_frames(5);
    ans = 10'd511;
    push_frame(BL, dg[5], dg[1], dg[1]);
    wait_frames(6);
    ans = 10'd123;
    repeat (3) @(negedge clk);
    chk("pre_err_busy", int'(busy), 1);
    error = 1'b1;
    @(negedge clk);
    chk("err_seg", int'(seg), int'(EE));
    chk("err_dp", int'(dp), 0);
    chk("err_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("err_hold_seg%0d", i), int'(seg), int'(EE));
    end
    error = 1'b0;
    push_frame(BL, dg[1], dg[2], dg[3]);
    wait_dp(cnt);
    chk("err_recover_latency", cnt, 13);
    wait_frames(7);
    push_frame(BL, dg[1], dg[2], dg[3]);
    wait_dp(cnt);
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_seg", int'(seg), 0);
    chk("midrst_dp", int'(dp), 0);
    chk("midrst_busy", int'(busy), 0);
    push_frame(BL, dg[1], dg[2], dg[3]);
    #4 rst_n = 1'b1;
    wait_dp(cnt);
    chk("rst_recover_latency", cnt, 12);
    wait_frames(8);
    chk("sb_empty", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test end");
    $fatal(1, "watchdog");
  end
endmodule
